// File: rtl/rop_pkg.sv
// Shared definitions for the ROP write combiner.
//   state_t       : combiner FSM states (EMPTY, FILL, FLUSH)
//   beat_shift()  : log2 of the beat size in bytes
//   line_shift()  : log2 of the line size in bytes
//   params_legal(): elaboration-time sanity check of the top-level parameters
package rop_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int beat_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int line_shift(input int data_width, input int beats_per_line);
        return beat_shift(data_width) + $clog2(beats_per_line);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int data_width, input int addr_width,
                                        input int beats_per_line, input int timeout);
        return is_pow2(data_width) && (data_width >= 8) &&
               is_pow2(beats_per_line) && (beats_per_line >= 2) &&
               (timeout >= 1) &&
               (addr_width > line_shift(data_width, beats_per_line));
    endfunction

endpackage

// File: rtl/rop_idle_timer.sv
// Idle counter for the write combiner.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart counting from zero (a beat was accepted / fresh line)
//   inc      : one idle cycle elapsed
//   expired  : count has reached TIMEOUT-1; the next idle edge is the timeout
module rop_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // Saturate rather than wrap so a stray increment can never re-arm the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/rop_write_combiner.sv
// Write combiner behind the MRT write arbiter: merges single-beat colour writes
// hitting the same line into one line-wide burst with per-beat enables.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : beat handshake; in_data, in_addr (byte address)
//   out_valid/out_ready : burst handshake; out_addr (line aligned),
//                         out_data (beat k at k*DATA_WIDTH), out_beat_en
//   flush_req           : drain everything buffered
//   flush_done          : one-cycle pulse once the drain has completed
module rop_write_combiner
    import rop_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int BEATS_PER_LINE = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic [ADDR_WIDTH-1:0]                in_addr,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ADDR_WIDTH-1:0]                out_addr,
    output logic [BEATS_PER_LINE*DATA_WIDTH-1:0] out_data,
    output logic [BEATS_PER_LINE-1:0]            out_beat_en,
    input  logic                                 flush_req,
    output logic                                 flush_done
);

    localparam int BEAT_SHIFT = beat_shift(DATA_WIDTH);
    localparam int LINE_SHIFT = line_shift(DATA_WIDTH, BEATS_PER_LINE);
    localparam int IDX_W      = $clog2(BEATS_PER_LINE);
    localparam int TAG_W      = ADDR_WIDTH - LINE_SHIFT;

    if (!params_legal(DATA_WIDTH, ADDR_WIDTH, BEATS_PER_LINE, TIMEOUT)) begin : g_bad_params
        $error("rop_write_combiner: illegal parameter combination");
    end

    state_t                           state;
    logic [TAG_W-1:0]                 line_tag;
    logic [BEATS_PER_LINE*DATA_WIDTH-1:0] line_data;
    logic [BEATS_PER_LINE-1:0]        line_en;
    logic                             hold_valid;
    logic [TAG_W-1:0]                 hold_tag;
    logic [IDX_W-1:0]                 hold_idx;
    logic [DATA_WIDTH-1:0]            hold_data;
    logic                             flush_pend;

    logic [TAG_W-1:0]                 in_tag;
    logic [IDX_W-1:0]                 in_idx;
    logic [BEATS_PER_LINE-1:0]        in_onehot;
    logic [BEATS_PER_LINE-1:0]        hold_onehot;
    logic [BEATS_PER_LINE-1:0]        hit_en;
    logic                             accept;
    logic                             tag_hit;
    logic                             expired;
    logic                             timer_clear;
    logic                             timer_inc;
    logic                             addr_unused;

    assign in_tag      = in_addr[ADDR_WIDTH-1:LINE_SHIFT];
    assign in_idx      = in_addr[LINE_SHIFT-1:BEAT_SHIFT];
    assign addr_unused = ^in_addr[BEAT_SHIFT-1:0];
    assign in_onehot   = {{(BEATS_PER_LINE-1){1'b0}}, 1'b1} << in_idx;
    assign hold_onehot = {{(BEATS_PER_LINE-1){1'b0}}, 1'b1} << hold_idx;
    assign hit_en      = line_en | in_onehot;
    assign tag_hit     = (in_tag == line_tag);

    // Decoded from registers only so the arbiter never sees a combinational
    // path from its own valid/address back into ready.
    assign in_ready = ((state == EMPTY) || (state == FILL)) && !flush_pend;
    assign accept   = in_valid && in_ready;

    // A held beat re-enters as a fresh line, so it restarts the idle window.
    assign timer_clear = accept || ((state == FLUSH) && out_ready && hold_valid);
    assign timer_inc   = (state == FILL) && !accept;

    rop_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (expired)
    );

    assign out_addr    = {line_tag, {LINE_SHIFT{1'b0}}};
    assign out_data    = line_data;
    assign out_beat_en = line_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            line_tag   <= '0;
            line_data  <= '0;
            line_en    <= '0;
            hold_valid <= 1'b0;
            hold_tag   <= '0;
            hold_idx   <= '0;
            hold_data  <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            // Clearing in EMPTY below overrides this, so a request landing on
            // the completing edge is absorbed by the drain already finishing.
            if (flush_req) begin
                flush_pend <= 1'b1;
            end

            case (state)
                EMPTY: begin
                    if (flush_pend) begin
                        flush_done <= 1'b1;
                        flush_pend <= 1'b0;
                    end
                    if (accept) begin
                        line_tag <= in_tag;
                        line_en  <= in_onehot;
                        for (int k = 0; k < BEATS_PER_LINE; k++) begin
                            if (in_idx == IDX_W'(k)) begin
                                line_data[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                            end
                        end
                        state <= FILL;
                    end
                end

                FILL: begin
                    if (accept) begin
                        if (tag_hit) begin
                            for (int k = 0; k < BEATS_PER_LINE; k++) begin
                                if (in_idx == IDX_W'(k)) begin
                                    line_data[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                                end
                            end
                            line_en <= hit_en;
                            if (&hit_en) begin
                                state     <= FLUSH;
                                out_valid <= 1'b1;
                            end
                        end else begin
                            hold_valid <= 1'b1;
                            hold_tag   <= in_tag;
                            hold_idx   <= in_idx;
                            hold_data  <= in_data;
                            state      <= FLUSH;
                            out_valid  <= 1'b1;
                        end
                    end else if (expired || flush_pend) begin
                        state     <= FLUSH;
                        out_valid <= 1'b1;
                    end
                end

                FLUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (hold_valid) begin
                            hold_valid <= 1'b0;
                            line_tag   <= hold_tag;
                            line_en    <= hold_onehot;
                            for (int k = 0; k < BEATS_PER_LINE; k++) begin
                                if (hold_idx == IDX_W'(k)) begin
                                    line_data[k*DATA_WIDTH +: DATA_WIDTH] <= hold_data;
                                end
                            end
                            state <= FILL;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end

                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rop_write_combiner.sv
// Directed bench for rop_write_combiner: stimulus pushes expected bursts into a
// queue, a negedge monitor pops and compares each burst handshake.
module tb_rop_write_combiner;

    localparam int DW  = 128;
    localparam int AW  = 32;
    localparam int BPL = 4;
    localparam int TO  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic [AW-1:0]       in_addr;
    logic                out_valid;
    logic                out_ready;
    logic [AW-1:0]       out_addr;
    logic [BPL*DW-1:0]   out_data;
    logic [BPL-1:0]      out_beat_en;
    logic                flush_req;
    logic                flush_done;

    rop_write_combiner #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .BEATS_PER_LINE (BPL),
        .TIMEOUT        (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_addr     (in_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_beat_en (out_beat_en),
        .flush_req   (flush_req),
        .flush_done  (flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]     addr;
        logic [BPL-1:0]    en;
        logic [BPL*DW-1:0] data;
    } burst_t;

    burst_t exp_q[$];
    burst_t mon_e;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [AW-1:0] a, input logic [7:0] s);
        return {a, 24'h0, s, ~a, a ^ 32'h5a5a_5a5a};
    endfunction

    task automatic expect_burst(input logic [AW-1:0] a, input logic [BPL-1:0] en,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        burst_t b;
        b.addr = a;
        b.en   = en;
        b.data = {d3, d2, d1, d0};
        exp_q.push_back(b);
    endtask

    // Scoreboard monitor: a burst handshake completes on the edge after this sample.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL burst_unexpected actual=%0h required=none", out_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("burst_addr", out_addr, mon_e.addr);
                check("burst_en", out_beat_en, mon_e.en);
                for (int k = 0; k < BPL; k++) begin
                    if (mon_e.en[k]) begin
                        check("burst_slot", out_data[k*DW +: DW], mon_e.data[k*DW +: DW]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("send_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 100);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!flush_done && n < 100);
    endtask

    logic [DW-1:0] da, db;
    int            n;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        out_ready = 1'b1;
        flush_req = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", |out_data, 0);
        check("rst_out_beat_en", out_beat_en, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Full line, back to back
        expect_burst(32'h1000, 4'b1111, mk(32'h1000, 8'h01), mk(32'h1010, 8'h02),
                     mk(32'h1020, 8'h03), mk(32'h1030, 8'h04));
        send(32'h1000, mk(32'h1000, 8'h01));
        send(32'h1010, mk(32'h1010, 8'h02));
        send(32'h1020, mk(32'h1020, 8'h03));
        send(32'h1030, mk(32'h1030, 8'h04));
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        tick();
        check("full_done_valid", out_valid, 0);

        // Miss with a 10-cycle stall, then the held beat times out
        out_ready = 1'b0;
        da = mk(32'h2010, 8'h11);
        db = mk(32'h3000, 8'h12);
        expect_burst(32'h2000, 4'b0010, '0, da, '0, '0);
        expect_burst(32'h3000, 4'b0001, db, '0, '0, '0);
        send(32'h2010, da);
        send(32'h3000, db);
        check("miss_out_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_out_addr", out_addr, 32'h2000);
            check("stall_out_en", out_beat_en, 4'b0010);
            check("stall_slot1", out_data[DW +: DW], da);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("held_refill_valid", out_valid, 0);
        wait_valid(n);
        check("held_timeout_edges", n, TO);
        tick();

        // Same beat twice: later data wins, timeout from the second accept
        da = mk(32'h4020, 8'h21);
        db = mk(32'h4020, 8'h22);
        expect_burst(32'h4000, 4'b0100, '0, '0, db, '0);
        send(32'h4020, da);
        send(32'h4020, db);
        wait_valid(n);
        check("overwrite_timeout_edges", n, TO);
        tick();

        // Flush of a partial line
        expect_burst(32'h5000, 4'b1001, mk(32'h5000, 8'h31), '0, '0, mk(32'h5030, 8'h32));
        send(32'h5000, mk(32'h5000, 8'h31));
        send(32'h5030, mk(32'h5030, 8'h32));
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("flush_fill_in_ready", in_ready, 0);
        wait_done(n);
        check("flush_fill_done_edges", n, 3);
        tick();
        check("flush_done_pulse", flush_done, 0);

        // Flush while empty
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("flush_empty_in_ready", in_ready, 0);
        wait_done(n);
        check("flush_empty_done_edges", n, 1);
        tick();

        // Flush together with a beat in EMPTY
        expect_burst(32'h6000, 4'b0010, '0, mk(32'h6010, 8'h41), '0, '0);
        check("simul_in_ready", in_ready, 1);
        flush_req = 1'b1;
        in_valid  = 1'b1;
        in_addr   = 32'h6010;
        in_data   = mk(32'h6010, 8'h41);
        tick();
        flush_req = 1'b0;
        in_valid  = 1'b0;
        wait_done(n);
        check("simul_done_edges", n, 3);
        tick();

        // Async reset while a burst is pending with a held beat
        out_ready = 1'b0;
        send(32'h7000, mk(32'h7000, 8'h51));
        send(32'h8000, mk(32'h8000, 8'h52));
        check("prereset_out_valid", out_valid, 1);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_addr", out_addr, 0);
        check("arst_out_data", |out_data, 0);
        check("arst_out_beat_en", out_beat_en, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        expect_burst(32'h9000, 4'b0011, mk(32'h9000, 8'h61), mk(32'h9010, 8'h62), '0, '0);
        send(32'h9000, mk(32'h9000, 8'h61));
        send(32'h9010, mk(32'h9010, 8'h62));
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        wait_done(n);
        check("post_reset_done_edges", n, 3);

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rop_write_combiner.md
# rop_write_combiner

Write-combining stage directly downstream of the MRT write arbiter in the ROP output path. Consumes the arbiter's single-beat colour writes (128-bit data, byte address) and merges beats that hit the same 64-byte line into one line-wide burst with per-beat enables for the memory interface. Partial lines leave on one of three events: a line miss, an idle timeout, or an explicit end-of-draw flush request.

## Interface
- `DATA_WIDTH`, 128: beat width in bits; must be a power of two and ≥ 8.
- `ADDR_WIDTH`, 32: byte-address width.
- `BEATS_PER_LINE`, 4: beats per line; must be a power of two and ≥ 2.
- `TIMEOUT`, 16: idle cycles before a partial line is flushed; must be ≥ 1.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `in_valid`, in, 1: beat offered by the arbiter.
- `in_ready`, out, 1: beat accepted when `in_valid && in_ready` at a rising edge.
- `in_data`, in, DATA_WIDTH: beat data.
- `in_addr`, in, ADDR_WIDTH: byte address. The low log2(DATA_WIDTH/8) bits are ignored.
- `out_valid`, out, 1: line burst valid.
- `out_ready`, in, 1: memory accepts the burst.
- `out_addr`, out, ADDR_WIDTH: line-aligned byte address; the low LINE_SHIFT bits are 0.
- `out_data`, out, BEATS_PER_LINE*DATA_WIDTH: beat k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `out_beat_en`, out, BEATS_PER_LINE: bit k set means beat k is written.
- `flush_req`, in, 1: single-cycle request to drain all buffered data.
- `flush_done`, out, 1: one-cycle pulse when the drain is complete.

## Operation
- BEAT_SHIFT = log2(DATA_WIDTH/8). LINE_SHIFT = BEAT_SHIFT + log2(BEATS_PER_LINE).
- Tag = `in_addr[ADDR_WIDTH-1:LINE_SHIFT]`. Beat index = `in_addr[LINE_SHIFT-1:BEAT_SHIFT]`.
- Storage:
  - one line buffer: tag, data, beat_en;
  - one hold register for a missing beat;
  - `flush_pend` flag;
  - idle counter, width clog2(TIMEOUT+1).
- `in_ready` = (state is EMPTY or FILL) && !`flush_pend`. It is decoded from registers only and never depends on `in_valid` or `in_addr`.
- FSM states EMPTY, FILL, FLUSH:
  - **EMPTY.** An accepted beat loads the tag, writes its data slot, sets beat_en to one-hot of the beat index, clears the counter, and moves to FILL. If `flush_pend` is set, pulse `flush_done` and clear `flush_pend`.
  - **FILL, hit** (tag equal). Write the data slot and OR in its beat_en bit. A beat already present is overwritten: the later beat wins. Clear the counter. If beat_en becomes all-ones, go to FLUSH.
  - **FILL, miss.** Capture the beat in the hold register, set hold_valid, and go to FLUSH.
  - **FILL, no accept.** The counter increments. When counter == TIMEOUT-1 with no accept, go to FLUSH. Also go to FLUSH when `flush_pend` is set.
  - **FLUSH.** `out_valid`=1; `out_addr`, `out_data` and `out_beat_en` are held stable until `out_ready`. On handshake: if hold_valid, load the held beat as a fresh line, clear hold_valid, and go to FILL; otherwise go to EMPTY.
- `out_data` slots whose enable bit is clear are don't-care. The bench checks only the enabled beats.
- `flush_req` sets `flush_pend`. A `flush_req` while `flush_pend` is already set has no further effect.

## Timing
- Reset values:
  - `out_valid`=0, `out_addr`=0, `out_data`=0, `out_beat_en`=0, `flush_done`=0;
  - state EMPTY, so `in_ready`=1;
  - hold_valid=0, `flush_pend`=0, counter=0.
- Reset asserted mid-burst drops all buffered data immediately (asynchronous); no burst is issued.
- Full line: last beat accepted at edge N gives `out_valid`=1 after edge N.
- Miss: the miss beat is accepted at edge N, and `out_valid`=1 after edge N. The held beat re-enters FILL at the handshake edge. `in_ready` is 0 during FLUSH.
- Timeout: last accept at edge N, no further accepts, gives `out_valid`=1 after edge N+TIMEOUT.
- Flush:
  - In EMPTY, `flush_req` at edge N gives `flush_done` after edge N+1.
  - In FILL, `flush_req` at edge N gives FLUSH after N+1. The handshake is followed by EMPTY, and `flush_done` follows one edge later.
  - A held beat is drained as a second burst before `flush_done`.
- Simultaneous `flush_req` and `in_valid` in EMPTY: the beat is accepted (`in_ready` is still 1 that cycle) and the flush then drains it.
- Throughput: one beat per cycle while hitting. Each burst costs at least one FLUSH cycle with `in_ready`=0.

## Structure
- Package `rop_pkg` holds:
  - state enum {EMPTY, FILL, FLUSH};
  - functions for BEAT_SHIFT and LINE_SHIFT;
  - parameter legality checks.
- One sub-module, `rop_idle_timer`: the clear/increment counter with a `expired` output at TIMEOUT-1. Everything else stays in the top module.

## Test plan
- Beats at 0x1000, 0x1010, 0x1020, 0x1030 on back-to-back cycles → one burst: `out_addr`=0x1000, `out_beat_en`=4'b1111, data in slot order, `out_valid` one cycle after the 4th accept.
- Beats at 0x2010 then 0x3000 → burst 0x2000 with en=4'b0010 and `in_ready`=0 during FLUSH, then burst 0x3000 with en=4'b0001 after timeout.
- Beat at 0x4020 twice (data A then B), then idle with TIMEOUT=16 → burst 0x4000, en=4'b0100, slot 2 = B, `out_valid` rises 16 edges after the second accept.
- `out_ready` held low for 10 cycles during FLUSH → `out_addr`, `out_data` and `out_beat_en` stable throughout; no beats accepted.
- `flush_req` with line 0x5000 partially filled (en=4'b1001) → burst en=4'b1001, then `flush_done` one cycle after the handshake; `flush_req` in EMPTY → `flush_done` two edges later.
- `rst` asserted asynchronously while `out_valid`=1 → all outputs 0 immediately; the next beat after release starts a fresh line.
